// File: rtl/signed_mult_unit.sv
// Signed WxW multiplier: radix-2 Booth sequential core (done W cycles after start) plus a combinational Baugh-Wooley tree.
// Latency: sequential W cycles, tree 0 cycles. No backpressure; start is ignored while the sequential core is busy.
module signed_mult_unit #(
   parameter int W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic [2*W-1:0]   seq_product,
   output logic             seq_done,
   output logic [2*W-1:0]   tree_product
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           r_state;
   logic [W-1:0]     r_mcand;
   logic [W-1:0]     r_q;
   logic [W:0]       r_acc;
   logic             r_qm1;
   logic [CW-1:0]    r_cnt;
   logic [2*W-1:0]   r_seq_product;
   logic             r_seq_done;

   logic [W:0]       w_mcand_ext;
   logic [W:0]       w_sum;
   logic [2*W+1:0]   w_shift;

   // One Booth step: add/sub on the W+1 bit accumulator, then arithmetic shift of {acc, q, q_-1}.
   always_comb begin
      w_mcand_ext = {r_mcand[W-1], r_mcand};
      case ({r_q[0], r_qm1})
         2'b01:   w_sum = r_acc + w_mcand_ext;
         2'b10:   w_sum = r_acc - w_mcand_ext;
         default: w_sum = r_acc;
      endcase
      w_shift = {w_sum[W], w_sum, r_q};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_mcand       <= '0;
         r_q           <= '0;
         r_acc         <= '0;
         r_qm1         <= 1'b0;
         r_cnt         <= '0;
         r_seq_product <= '0;
         r_seq_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_mcand    <= a;
                  r_q        <= b;
                  r_qm1      <= 1'b0;
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_seq_done <= 1'b0;
                  r_state    <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_acc <= w_shift[2*W+1:W+1];
               r_q   <= w_shift[W:1];
               r_qm1 <= w_shift[0];
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(W - 1)) begin
                  r_seq_product <= w_shift[2*W:1];
                  r_seq_done    <= 1'b1;
                  r_state       <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign seq_product = r_seq_product;
   assign seq_done    = r_seq_done;

   // Baugh-Wooley rows: terms with exactly one MSB index are inverted; the correction bits seed the carry row.
   logic [2*W-1:0] w_tree_s;
   logic [2*W-1:0] w_tree_c;

   always_comb begin
      logic [2*W-1:0] w_row;
      logic [2*W-1:0] w_nxt_s;
      logic [2*W-1:0] w_nxt_c;
      w_tree_s = '0;
      w_tree_c = '0;
      w_tree_c[W]       = 1'b1;
      w_tree_c[2*W-1]   = 1'b1;
      for (int i = 0; i < W; i++) begin
         w_row = '0;
         for (int j = 0; j < W; j++) begin
            w_row[i+j] = (a[j] & b[i]) ^ ((i == W - 1) != (j == W - 1));
         end
         w_nxt_s  = w_tree_s ^ w_tree_c ^ w_row;
         w_nxt_c  = ((w_tree_s & w_tree_c) | (w_tree_s & w_row) | (w_tree_c & w_row)) << 1;
         w_tree_s = w_nxt_s;
         w_tree_c = w_nxt_c;
      end
   end

   assign tree_product = w_tree_s + w_tree_c;

endmodule

// File: tb/tb_signed_mult_unit.sv
// Scoreboard bench for signed_mult_unit: expected products and completion cycles are queued at issue, a monitor pops on each seq_done rise.
module tb_signed_mult_unit;

   localparam int W = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [W-1:0]      a = '0;
   logic [W-1:0]      b = '0;
   logic [2*W-1:0]    seq_product;
   logic              seq_done;
   logic [2*W-1:0]    tree_product;

   signed_mult_unit #(.W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .a            (a),
      .b            (b),
      .seq_product  (seq_product),
      .seq_done     (seq_done),
      .tree_product (tree_product)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint prod;
      int     cyc;
   } exp_t;

   exp_t   sbq[$];
   int     n_tests = 0;
   int     n_fail  = 0;
   int     cyc     = 0;
   logic   prev_done = 1'b0;
   longint last_exp = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic longint model(input logic [W-1:0] x, input logic [W-1:0] y);
      return longint'($signed(x)) * longint'($signed(y));
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: each rising seq_done must match the oldest pending request, on its exact cycle.
   always @(negedge clk) begin
      if (rst) begin
         prev_done = 1'b0;
      end else begin
         if (seq_done && !prev_done) begin
            if (sbq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("seq_product", longint'(seq_product), e.prod);
               chk("seq_latency", longint'(cyc), longint'(e.cyc));
            end
         end else if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
            exp_t e;
            e = sbq.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL seq_timeout: no done by cycle %0d, expected at %0d", cyc, e.cyc);
         end
         prev_done = seq_done;
      end
   end

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit accept);
      a = x;
      b = y;
      start = 1'b1;
      #1;
      chk("tree_product", longint'(tree_product), model(x, y));
      if (accept) begin
         sbq.push_back('{prod: model(x, y), cyc: cyc + 1 + W});
         last_exp = model(x, y);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("done_after_start", longint'(seq_done), 0);
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 4 * W; k++) begin
         if (sbq.size() == 0) break;
         @(negedge clk);
      end
      if (sbq.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_idle: %0d results still pending, expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] x;
      logic [W-1:0] y;

      // Reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_done", longint'(seq_done), 0);
      chk("reset_product", longint'(seq_product), 0);
      chk("reset_tree_zero", longint'(tree_product), 0);
      @(negedge clk);

      // Directed cases
      issue(32'd15, 32'd10, 1);
      wait_idle();
      chk("hold_150", longint'(seq_product), 150);
      issue(-32'sd25, 32'd12, 1);
      wait_idle();
      chk("hold_done", longint'(seq_done), 1);
      chk("hold_m300", longint'(seq_product), -300);
      issue(-32'sd8, -32'sd8, 1);
      wait_idle();
      issue(32'd0, 32'd123, 1);
      wait_idle();
      issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1);
      wait_idle();
      chk("max_pos", longint'(seq_product), 64'sd4611686014132420609);
      issue(32'h8000_0000, 32'h8000_0000, 1);
      wait_idle();
      chk("max_neg_sq", longint'(seq_product), 64'sd4611686018427387904);
      issue(32'h8000_0000, 32'd1, 1);
      wait_idle();
      chk("min_times_one", longint'(seq_product), -64'sd2147483648);

      // Reset 10 cycles after start aborts the operation with no later done
      issue(32'd1234, 32'd5678, 1);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      sbq.delete();
      #1;
      chk("abort_done", longint'(seq_done), 0);
      chk("abort_product", longint'(seq_product), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (W + 8) @(negedge clk);
      chk("abort_no_done", longint'(seq_done), 0);

      // Start while busy is ignored; first result arrives on time
      issue(32'd77, -32'sd3, 1);
      repeat (5) @(negedge clk);
      issue(32'd999, 32'd999, 0);
      wait_idle();
      chk("busy_ignore_hold", longint'(seq_product), -231);

      // Operands changing during BUSY do not disturb the captured copies
      issue(-32'sd1000, 32'd4321, 1);
      for (int k = 0; k < 12; k++) begin
         x = $urandom;
         y = $urandom;
         a = x;
         b = y;
         #1;
         chk("tree_during_busy", longint'(tree_product), model(x, y));
         @(negedge clk);
      end
      wait_idle();

      // Randomized operations with random idle gaps (gap 0 = back-to-back from DONE)
      for (int n = 0; n < 30; n++) begin
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 7))
            0: x = 32'h8000_0000;
            1: y = 32'h8000_0000;
            2: x = 32'hFFFF_FFFF;
            3: y = 32'd0;
            default: ;
         endcase
         issue(x, y, 1);
         wait_idle();
         repeat ($urandom_range(0, 3)) @(negedge clk);
         chk("sticky_product", longint'(seq_product), last_exp);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
